pc_gen: RTL



---
 rtl/pc_gen.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pc_gen.sv
// pc_gen: parametrised program-counter generator.
// Holds the architectural PC, produces PC+INC through a grouped
// carry-lookahead adder, resolves conditional PC-relative and
// register-indirect branches, and supports stall and a sticky HALTED state.
// WIDTH must be a multiple of CLA_W and wider than OFF_W.
module pc_gen #(
  parameter int              WIDTH     = 16,
  parameter int              CLA_W     = 4,
  parameter int              INC       = 2,
  parameter int              OFF_W     = 9,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             halt,
  input  logic             br_valid,
  input  logic             br_reg,
  input  logic [2:0]       cond,
  input  logic [2:0]       flags,
  input  logic [OFF_W-1:0] offset,
  input  logic [WIDTH-1:0] reg_target,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus,
  output logic             taken,
  output logic             halted
);

  localparam int NGRP = WIDTH / CLA_W;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] rel_disp;
  logic [WIDTH-1:0] rel_target;
  logic [WIDTH-1:0] target;
  logic             cond_met;
  logic             flag_z;
  logic             flag_v;
  logic             flag_n;

  // Grouped carry-lookahead adder: each CLA_W-bit group forms its own
  // generate/propagate pair, and group carries chain from the group
  // below. The carry out of the top group is never formed, so sums
  // wrap modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] cla_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] sum;
    logic [NGRP-1:0]  gcarry;
    logic             c;
    logic             grp_g;
    logic             grp_p;
    g      = a & b;
    p      = a ^ b;
    sum    = '0;
    gcarry = '0;
    for (int k = 0; k < NGRP; k++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      c     = gcarry[k];
      for (int i = 0; i < CLA_W; i++) begin
        sum[k*CLA_W+i] = p[k*CLA_W+i] ^ c;
        c              = g[k*CLA_W+i] | (p[k*CLA_W+i] & c);
        grp_g          = g[k*CLA_W+i] | (p[k*CLA_W+i] & grp_g);
        grp_p          = grp_p & p[k*CLA_W+i];
      end
      if (k < NGRP - 1) begin
        gcarry[k+1] = grp_g | (grp_p & gcarry[k]);
      end
    end
    return sum;
  endfunction

  assign {flag_z, flag_v, flag_n} = flags;

  assign inc_val    = WIDTH'(INC);
  assign pc_plus    = cla_add(pc_reg, inc_val);
  assign rel_disp   = {{(WIDTH-OFF_W-1){offset[OFF_W-1]}}, offset, 1'b0};
  assign rel_target = cla_add(pc_plus, rel_disp);
  assign target     = br_reg ? reg_target : rel_target;
  assign pc_out     = pc_reg;

  // Condition evaluation against the {Z,V,N} flag register.
  always_comb begin
    cond_met = 1'b0;
    case (cond)
      3'b000:  cond_met = ~flag_z;
      3'b001:  cond_met = flag_z;
      3'b010:  cond_met = ~flag_z & ~flag_n;
      3'b011:  cond_met = flag_n;
      3'b100:  cond_met = flag_z | ~flag_n;
      3'b101:  cond_met = flag_n | flag_z;
      3'b110:  cond_met = flag_v;
      default: cond_met = 1'b1;
    endcase
  end

  // A branch redirects only while running and only if no HLT sits at
  // the same address; stall is deliberately not folded in here.
  assign taken = (state == RUN) & br_valid & cond_met & ~halt;

  // PC and run/halt state update; stall outranks halt so a stalled HLT
  // is simply retried on the next unstalled cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg <= RESET_VEC;
      state  <= RUN;
      halted <= 1'b0;
    end else if (state == HALTED) begin
      pc_reg <= pc_reg;
    end else if (stall) begin
      pc_reg <= pc_reg;
    end else if (halt) begin
      state  <= HALTED;
      halted <= 1'b1;
    end else if (taken) begin
      pc_reg <= target;
    end else begin
      pc_reg <= pc_plus;
    end
  end

endmodule
